// File: rtl/hmmm_muldiv.sv
// hmmm_muldiv -- iterative signed multiply / divide / modulo unit for the
// HMMM core. It sits between the register file read ports (a = rd1,
// b = rd2) and the register file write port (done/wa_out/result drive
// we3/wa3/wd3).
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         request, accepted only while the FSM is in IDLE
//   op            00 mul, 01 div, 10 mod, 11 reserved (result 0)
//   a, b          operands, needed only in the start cycle
//   wa_in         destination register, captured with the operands
//   busy          high from the accept edge until the done cycle ends
//   done          one-cycle registered pulse (we3)
//   result        registered result (wd3), held until the next FIX
//   wa_out        captured destination (wa3)
//   div0          valid with done: div/mod was issued with b == 0
//
// Optional feature macro: HMMM_MULDIV_ZERO_SKIP_EN. When it is defined, an
// operation with a == 0 or b == 0 bypasses CALC and completes after 2 cycles.
//
// Division uses floor semantics: q = floor(a/b), r = a - q*b, and r takes
// the sign of b.
module hmmm_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       wa_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       wa_out,
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic             b_zero_reg;
    logic [WIDTH-1:0] mag_a_reg;   // multiplicand (shifted left) / dividend bits
    logic [WIDTH-1:0] mag_b_reg;   // multiplier (shifted right) / divisor
    logic [WIDTH-1:0] acc_reg;     // product / quotient magnitude
    logic [WIDTH-1:0] rem_reg;     // partial remainder magnitude
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH-1:0] b_signed;
    logic [WIDTH-1:0] prod_val;
    logic [WIDTH-1:0] q_val;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] fix_result;

    always_comb begin
        // Restoring step: bring in the next dividend bit, try subtracting.
        rem_shift = {rem_reg, mag_a_reg[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, mag_b_reg};

        b_signed = sign_b_reg ? -mag_b_reg : mag_b_reg;
        // Same sign correction serves the product and the truncated quotient.
        prod_val = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
        q_val    = prod_val;
        r_val    = sign_a_reg ? -rem_reg : rem_reg;
        // Truncated -> floored: pull a remainder of the wrong sign back
        // into b's sign and borrow one from the quotient.
        if (r_val != '0 && r_val[WIDTH-1] != sign_b_reg) begin
            q_val = q_val - WIDTH'(1);
            r_val = r_val + b_signed;
        end

        case (op_reg)
            2'b00:   fix_result = prod_val;
            2'b01:   fix_result = b_zero_reg ? '0 : q_val;
            2'b10:   fix_result = b_zero_reg ? '0 : r_val;
            default: fix_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            wa_out     <= '0;
            div0       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // IDLE also covers the done cycle, so busy stays high
                    // through it and drops one edge later unless a new
                    // request is accepted on that same edge.
                    busy <= start;
                    if (start) begin
                        op_reg     <= op;
                        wa_out     <= wa_in;
                        sign_a_reg <= a[WIDTH-1];
                        sign_b_reg <= b[WIDTH-1];
                        b_zero_reg <= (b == '0);
                        mag_a_reg  <= a[WIDTH-1] ? -a : a;
                        mag_b_reg  <= b[WIDTH-1] ? -b : b;
                        acc_reg    <= '0;
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
`ifdef HMMM_MULDIV_ZERO_SKIP_EN
                        // A zero operand gives the same answer from cleared
                        // accumulators, so the iterations can be skipped.
                        state_reg  <= (a == '0 || b == '0) ? FIX : CALC;
`else
                        state_reg  <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (op_reg == 2'b00) begin
                        if (mag_b_reg[0]) begin
                            acc_reg <= acc_reg + mag_a_reg;
                        end
                        mag_b_reg <= mag_b_reg >> 1;
                    end else begin
                        if (!rem_sub[WIDTH]) begin
                            rem_reg <= rem_sub[WIDTH-1:0];
                            acc_reg <= {acc_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_reg <= rem_shift[WIDTH-1:0];
                            acc_reg <= {acc_reg[WIDTH-2:0], 1'b0};
                        end
                    end
                    mag_a_reg <= mag_a_reg << 1;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    result    <= fix_result;
                    div0      <= (op_reg == 2'b01 || op_reg == 2'b10) && b_zero_reg;
                    state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
